// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control/status bundle between the multicycle
// controller (master) and its datapath (slave).
interface mc_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       less_than;
  logic       overflow_flag;
  logic       mem_ready;
  logic [1:0] alu_sel;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] ext_op;
  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] pc_src;
  logic       reg_dst;
  logic [1:0] mem_to_reg;
  logic       slt_bit;
  logic [3:0] state;
  logic       ovf_exc;

  modport master (
    input  opcode, funct, zero, less_than,
    input  overflow_flag, mem_ready,
    output alu_sel, alu_src_a, alu_src_b, ext_op,
    output pc_write, ir_write, reg_write,
    output mem_read, mem_write, pc_src, reg_dst,
    output mem_to_reg, slt_bit, state, ovf_exc
  );

  modport slave (
    output opcode, funct, zero, less_than,
    output overflow_flag, mem_ready,
    input  alu_sel, alu_src_a, alu_src_b, ext_op,
    input  pc_write, ir_write, reg_write,
    input  mem_read, mem_write, pc_src, reg_dst,
    input  mem_to_reg, slt_bit, state, ovf_exc
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS-subset control FSM.
// Define OVERFLOW_TRAP_EN to add the add/sub overflow TRAP state.
module mc_ctrl (
  input logic        clk,
  input logic        rst_n,
  mc_ctrl_if.master  bus
);

`ifdef OVERFLOW_TRAP_EN
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2,
    R_WB = 4'd3, EXEC_I = 4'd4, I_WB = 4'd5,
    MEM_ADDR = 4'd6, MEM_RD = 4'd7, MEM_WB = 4'd8,
    MEM_WR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11,
    TRAP = 4'd12
  } state_t;
`else
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, EXEC_R = 4'd2,
    R_WB = 4'd3, EXEC_I = 4'd4, I_WB = 4'd5,
    MEM_ADDR = 4'd6, MEM_RD = 4'd7, MEM_WB = 4'd8,
    MEM_WR = 4'd9, BRANCH = 4'd10, JUMP = 4'd11
  } state_t;
`endif

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;

  state_t     st, nxt;
  logic [5:0] op_q, fn_q;
  logic       slt_q;

  logic r_fn_ok;
  logic dec_r, dec_i, dec_m, dec_b, dec_j;
  logic l_add, l_addu, l_slt, l_lui, l_lw;

  logic [1:0] alu_sel, alu_src_b, ext_op;
  logic [1:0] pc_src, mem_to_reg;
  logic       alu_src_a, reg_dst, mem_read;
  logic       pcw_c, irw_c, rw_c, mw_c, ovf_c;

  // Live decode selects the DECODE successor.
  assign r_fn_ok = (bus.funct == FN_ADDU) ||
                   (bus.funct == FN_SUBU) ||
                   (bus.funct == FN_SLT)  ||
                   (bus.funct == FN_ADD)  ||
                   (bus.funct == FN_SUB);
  assign dec_r = (bus.opcode == OP_R) && r_fn_ok;
  assign dec_i = (bus.opcode == OP_ORI) ||
                 (bus.opcode == OP_LUI);
  assign dec_m = (bus.opcode == OP_LW) ||
                 (bus.opcode == OP_SW);
  assign dec_b = (bus.opcode == OP_BEQ);
  assign dec_j = (bus.opcode == OP_J);

  assign l_add  = (fn_q == FN_ADD)  || (fn_q == FN_SUB);
  assign l_addu = (fn_q == FN_ADDU) || (fn_q == FN_ADD);
  assign l_slt  = (fn_q == FN_SLT);
  assign l_lui  = (op_q == OP_LUI);
  assign l_lw   = (op_q == OP_LW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= FETCH;
      op_q  <= '0;
      fn_q  <= '0;
      slt_q <= 1'b0;
    end else begin
      st <= nxt;
      if (st == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
      if (st == EXEC_R && l_slt)
        slt_q <= bus.less_than;
    end
  end

  always_comb begin
    nxt        = st;
    alu_sel    = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_op     = 2'b00;
    pc_src     = 2'b00;
    mem_to_reg = 2'b00;
    reg_dst    = 1'b0;
    mem_read   = 1'b0;
    pcw_c      = 1'b0;
    irw_c      = 1'b0;
    rw_c       = 1'b0;
    mw_c       = 1'b0;
    ovf_c      = 1'b0;
    unique case (st)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        pcw_c     = bus.mem_ready;
        irw_c     = bus.mem_ready;
        if (bus.mem_ready) nxt = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 2'b01;
        unique case (1'b1)
          dec_r:   nxt = EXEC_R;
          dec_i:   nxt = EXEC_I;
          dec_m:   nxt = MEM_ADDR;
          dec_b:   nxt = BRANCH;
          dec_j:   nxt = JUMP;
          default: nxt = FETCH;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_sel   = l_addu ? 2'b00 : 2'b01;
        nxt       = R_WB;
`ifdef OVERFLOW_TRAP_EN
        if (l_add && bus.overflow_flag) nxt = TRAP;
`endif
      end
      R_WB: begin
        rw_c       = 1'b1;
        reg_dst    = 1'b1;
        mem_to_reg = l_slt ? 2'b10 : 2'b00;
        nxt        = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_sel   = 2'b10;
        ext_op    = l_lui ? 2'b10 : 2'b00;
        nxt       = I_WB;
      end
      I_WB: begin
        rw_c = 1'b1;
        nxt  = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_op    = 2'b01;
        nxt       = l_lw ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        if (bus.mem_ready) nxt = MEM_WB;
      end
      MEM_WB: begin
        rw_c       = 1'b1;
        mem_to_reg = 2'b01;
        nxt        = FETCH;
      end
      MEM_WR: begin
        mw_c = 1'b1;
        if (bus.mem_ready) nxt = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_sel   = 2'b01;
        pc_src    = 2'b01;
        pcw_c     = bus.zero;
        nxt       = FETCH;
      end
      JUMP: begin
        pc_src = 2'b10;
        pcw_c  = 1'b1;
        nxt    = FETCH;
      end
`ifdef OVERFLOW_TRAP_EN
      TRAP: begin
        ovf_c = 1'b1;
        nxt   = FETCH;
      end
`endif
      default: nxt = FETCH;
    endcase
  end

  // Write enables are held off combinationally while in reset.
  assign bus.pc_write   = pcw_c & rst_n;
  assign bus.ir_write   = irw_c & rst_n;
  assign bus.reg_write  = rw_c & rst_n;
  assign bus.mem_write  = mw_c & rst_n;
  assign bus.mem_read   = mem_read;
  assign bus.alu_sel    = alu_sel;
  assign bus.alu_src_a  = alu_src_a;
  assign bus.alu_src_b  = alu_src_b;
  assign bus.ext_op     = ext_op;
  assign bus.pc_src     = pc_src;
  assign bus.reg_dst    = reg_dst;
  assign bus.mem_to_reg = mem_to_reg;
  assign bus.slt_bit    = slt_q;
  assign bus.state      = st;
`ifdef OVERFLOW_TRAP_EN
  assign bus.ovf_exc    = ovf_c;
`else
  assign bus.ovf_exc    = 1'b0 & ovf_c;
`endif

endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 Parameters SHALL be none; all encodings below are fixed.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 opcode  in  6  instruction-register bits [31:26], valid from DECODE onward.
REQ-005 funct  in  6  instruction-register bits [5:0].
REQ-006 zero, less_than, overflow_flag  in  1 each  ALU status flags from the current cycle's ALU operation.
REQ-007 mem_ready  in  1  memory has completed the current read or write this cycle.
REQ-008 alu_sel  out  2  ALU operation: 00 add, 01 sub, 10 or.
REQ-009 alu_src_a  out  1  0 PC, 1 rs.
REQ-010 alu_src_b  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2.
REQ-011 ext_op  out  2  00 zero-extend, 01 sign-extend, 10 imm<<16.
REQ-012 pc_write, ir_write, reg_write, mem_read, mem_write  out  1 each  datapath enables.
REQ-013 pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target.
REQ-014 reg_dst  out  1  0 rt, 1 rd.
REQ-015 mem_to_reg  out  2  00 ALUOut, 01 memory data, 10 {31'b0,slt_bit}.
REQ-016 slt_bit  out  1  registered less_than from the last slt execute.
REQ-017 state  out  4  current state code, for debug.
REQ-018 ovf_exc  out  1  overflow trap pulse (see Configuration).

Function
REQ-019 Outputs not listed for a state SHALL be 0.
REQ-020 Supported instructions: R-type (opcode 000000) addu 100001, subu 100011, slt 101010; ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010.
REQ-021 Every unsupported opcode or funct SHALL return DECODE->FETCH with no write enable asserted.
REQ-022 FETCH(0): mem_read=1, alu_src_a=0, alu_src_b=01, alu_sel=00, pc_src=00; ir_write=pc_write=mem_ready; on mem_ready go to DECODE, else stay.
REQ-023 DECODE(1): alu_src_a=0, alu_src_b=11, ext_op=01, alu_sel=00; next state by opcode: R->EXEC_R, ori/lui->EXEC_I, lw/sw->MEM_ADDR, beq->BRANCH, j->JUMP.
REQ-024 EXEC_R(2): alu_src_a=1, alu_src_b=00, alu_sel=00 for addu, 01 for subu/slt; for slt, slt_bit SHALL load less_than at the end of the cycle; next R_WB.
REQ-025 R_WB(3): reg_write=1, reg_dst=1, mem_to_reg=10 for slt else 00; next FETCH.
REQ-026 EXEC_I(4): alu_src_a=1, alu_src_b=10, alu_sel=10, ext_op=00 for ori, 10 for lui; next I_WB.
REQ-027 I_WB(5): reg_write=1, reg_dst=0, mem_to_reg=00; next FETCH.
REQ-028 MEM_ADDR(6): alu_src_a=1, alu_src_b=10, ext_op=01, alu_sel=00; next MEM_RD for lw, MEM_WR for sw.
REQ-029 MEM_RD(7): mem_read=1 held until mem_ready, then MEM_WB.
REQ-030 MEM_WB(8): reg_write=1, reg_dst=0, mem_to_reg=01; next FETCH.
REQ-031 MEM_WR(9): mem_write=1 held until mem_ready, then FETCH.
REQ-032 BRANCH(10): alu_src_a=1, alu_src_b=00, alu_sel=01, pc_src=01, pc_write=zero; next FETCH.
REQ-033 JUMP(11): pc_src=10, pc_write=1; next FETCH.
REQ-034 Waiting on mem_ready SHALL be unbounded; opcode/funct changes while waiting SHALL not alter the path.
REQ-035 pc_write and ir_write SHALL be Mealy (same-cycle) on mem_ready/zero; all other outputs SHALL depend on state and latched opcode/funct only.

Reset
REQ-036 rst_n low SHALL immediately force state=FETCH, slt_bit=0, ovf_exc=0, and gate pc_write, ir_write, reg_write, mem_write to 0 for as long as rst_n is low.
REQ-037 Reset mid-instruction SHALL abandon it; the first cycle after release is FETCH.

Configuration
REQ-038 With OVERFLOW_TRAP_EN defined: R-type add 100000 and sub 100010 are decoded (alu_sel 00/01); overflow_flag=1 in EXEC_R for add/sub SHALL go to TRAP(12), which asserts ovf_exc for one cycle with reg_write=0, then FETCH.
REQ-039 Without OVERFLOW_TRAP_EN: add/sub execute exactly as addu/subu, TRAP state does not exist, ovf_exc is tied 0.

Verification
REQ-040 addu, mem_ready=1 in FETCH -> states 0,1,2,3,0; reg_write=1 with reg_dst=1 only in state 3.
REQ-041 lw, mem_ready low for 3 cycles in MEM_RD -> stays in state 7 for 4 cycles, mem_read=1 throughout, then 8 with mem_to_reg=01.
REQ-042 beq, zero=1 -> pc_write=1, pc_src=01 in state 10; zero=0 -> pc_write=0.
REQ-043 slt, less_than=1 in EXEC_R -> slt_bit=1, R_WB with mem_to_reg=10.
REQ-044 With OVERFLOW_TRAP_EN, add with overflow_flag=1 -> state 12, ovf_exc one cycle, no reg_write; without the macro -> R_WB with reg_write=1.
REQ-045 rst_n low during MEM_WR -> mem_write=0 immediately, state=0 after release.
